// File: rtl/isa_pkg.sv
// Shared definitions for the 5-bit-opcode instruction format: opcodes, field
// geometry, instruction classes and the loader FSM state encoding.
package isa_pkg;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_CNB  = 5'b00101;
    localparam logic [4:0] OP_MOD  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BGT  = 5'b01001;
    localparam logic [4:0] OP_ADDI = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b10001;
    localparam logic [4:0] OP_SLL  = 5'b10010;
    localparam logic [4:0] OP_SB   = 5'b10011;
    localparam logic [4:0] OP_LB   = 5'b10100;
    localparam logic [4:0] OP_LW   = 5'b10101;

    // Field geometry
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int REG_W  = 4;
    localparam int IMM_W  = 19;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_SHIFT,
        CLS_B,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } enc_state_e;

    // Observability bundle: FSM state plus the class of the instruction
    // currently presented on the input stream.
    typedef struct packed {
        enc_state_e   state;
        instr_class_e in_cls;
    } enc_dbg_t;

    function automatic instr_class_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_AND, OP_SUB, OP_MUL, OP_CNB, OP_MOD: return CLS_R;
            OP_ADDI, OP_SB, OP_LB, OP_LW:                   return CLS_I;
            OP_SRL, OP_SLL:                                 return CLS_SHIFT;
            OP_BEQ, OP_BGT:                                 return CLS_B;
            default:                                        return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction stream (host -> encoder) and instruction-memory write port
// (encoder -> memory) bundled into one interface.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// exactly when valid (in_valid / imem_we) and ready (in_ready / imem_ready)
// are both 1; while valid is high and ready is low the sender holds every
// payload signal stable; ready may depend combinationally on state but
// valid never depends on ready.
interface instr_encoder_if #(
    parameter int IMEM_AW = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [4:0]                  in_op;
    logic [isa_pkg::REG_W-1:0]   in_rd;
    logic [isa_pkg::REG_W-1:0]   in_rs1;
    logic [isa_pkg::REG_W-1:0]   in_rs2;
    logic [31:0]                 in_imm;
    logic                        imem_we;
    logic                        imem_ready;
    logic [IMEM_AW-1:0]          imem_addr;
    logic [31:0]                 imem_wdata;

    // Host and memory side
    modport master (
        output in_valid, in_last, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // Encoder side
    modport slave (
        input  in_valid, in_last, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: classifies an opcode, range-checks the immediate and
// builds the 32-bit instruction word. Word is zero when the instruction is
// illegal.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]       op,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [31:0]      imm,
    output instr_class_e     cls,
    output logic             legal,
    output logic [31:0]      word
);

    localparam int F1_MSB = OP_LSB - 1;          // first register field
    localparam int F2_MSB = OP_LSB - 1 - REG_W;  // second register field
    localparam int F3_MSB = IMM_W - 1;           // third register field

    logic imm19_ok;
    logic shamt_ok;

    // Signed 19-bit fit: all bits above the field sign bit equal it.
    assign imm19_ok = (&imm[31:IMM_W-1]) || !(|imm[31:IMM_W-1]);
    assign shamt_ok = !(|imm[31:5]);
    assign cls      = op_class(op);

    // Field placement per instruction class.
    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (cls)
            CLS_R: begin
                legal                    = 1'b1;
                word[OP_MSB:OP_LSB]      = op;
                word[F1_MSB -: REG_W]    = rd;
                word[F2_MSB -: REG_W]    = rs1;
                word[F3_MSB -: REG_W]    = rs2;
            end
            CLS_I: begin
                legal                    = imm19_ok;
                word[OP_MSB:OP_LSB]      = op;
                word[F1_MSB -: REG_W]    = rd;
                word[F2_MSB -: REG_W]    = rs1;
                word[IMM_W-1:0]          = imm[IMM_W-1:0];
            end
            CLS_SHIFT: begin
                legal                    = shamt_ok;
                word[OP_MSB:OP_LSB]      = op;
                word[F1_MSB -: REG_W]    = rd;
                word[F2_MSB -: REG_W]    = rs1;
                word[4:0]                = imm[4:0];
            end
            CLS_B: begin
                legal                    = imm19_ok;
                word[OP_MSB:OP_LSB]      = op;
                word[F1_MSB -: REG_W]    = rs1;
                word[F2_MSB -: REG_W]    = rs2;
                word[IMM_W-1:0]          = imm[IMM_W-1:0];
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
        if (!legal) begin
            word = '0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic instructions, rejects illegal ones, and
// writes packed words sequentially into instruction memory through a
// one-entry output register with backpressure.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] base_addr,
    instr_encoder_if.slave     bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [4:0]         err_op,
    output logic [ERR_W-1:0]   err_count,
    output enc_dbg_t           dbg
);

    localparam logic [IMEM_AW-1:0] PTR_MAX = '1;
    localparam logic [IMEM_AW-1:0] PTR_ONE = 1;
    localparam logic [ERR_W-1:0]   CNT_MAX = '1;
    localparam logic [ERR_W-1:0]   CNT_ONE = 1;

    enc_state_e         state_q, state_d;
    logic [IMEM_AW-1:0] wptr_q;
    logic [IMEM_AW-1:0] addr_q;
    logic [31:0]        data_q;
    logic               we_q;
    logic               full_q;
    logic               err_q;
    logic [4:0]         err_op_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               done_q;

    instr_class_e       cls;
    logic               legal;
    logic [31:0]        word;

    logic               in_ready_c;
    logic               xfer;
    logic               wr_done;
    logic               eff_full;
    logic [IMEM_AW-1:0] eff_ptr;
    logic               accept_word;
    logic               reject;
    logic               flush_done;

    instr_pack u_pack (
        .op    (bus.in_op),
        .rd    (bus.in_rd),
        .rs1   (bus.in_rs1),
        .rs2   (bus.in_rs2),
        .imm   (bus.in_imm),
        .cls   (cls),
        .legal (legal),
        .word  (word)
    );

    // The output register can take a new word when empty or when it is
    // emptying on this same edge, which gives back-to-back throughput.
    assign in_ready_c = (state_q == ST_LOAD) && (!we_q || bus.imem_ready);
    assign xfer       = bus.in_valid && in_ready_c;
    assign wr_done    = we_q && bus.imem_ready;

    // A write completing now at the last address exhausts the space for the
    // instruction accepted on the same edge; otherwise the new word goes one
    // past the address being written.
    assign eff_full    = full_q || (wr_done && (wptr_q == PTR_MAX));
    assign eff_ptr     = wr_done ? (wptr_q + PTR_ONE) : wptr_q;
    assign accept_word = xfer && legal && !eff_full;
    assign reject      = xfer && (!legal || eff_full);

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer && bus.in_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!we_q || bus.imem_ready) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer, output register, error tracking and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            err_op_q  <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= flush_done;
            if (state_q == ST_IDLE && start) begin
                wptr_q    <= base_addr;
                full_q    <= 1'b0;
                err_q     <= 1'b0;
                err_op_q  <= '0;
                err_cnt_q <= '0;
            end else begin
                if (wr_done) begin
                    if (wptr_q == PTR_MAX) begin
                        full_q <= 1'b1;
                    end else begin
                        wptr_q <= wptr_q + PTR_ONE;
                    end
                end
                if (reject) begin
                    err_q <= 1'b1;
                    if (!err_q) begin
                        err_op_q <= bus.in_op;
                    end
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + CNT_ONE;
                    end
                end
            end
            if (accept_word) begin
                we_q   <= 1'b1;
                addr_q <= eff_ptr;
                data_q <= word;
            end else if (wr_done) begin
                we_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = data_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign err_op         = err_op_q;
    assign err_count      = err_cnt_q;
    assign dbg.state      = state_q;
    assign dbg.in_cls     = cls;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one 256-word instance and one 4-word
// instance to reach the address-space-full boundary.
module tb_instr_encoder;
    import isa_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, start1;
    logic [7:0] base0;
    logic [1:0] base1;
    logic       busy0, busy1, done0, done1, err0, err1;
    logic [4:0] err_op0, err_op1;
    logic [7:0] err_count0, err_count1;
    enc_dbg_t   dbg0, dbg1;

    instr_encoder_if #(.IMEM_AW(8)) b0 ();
    instr_encoder_if #(.IMEM_AW(2)) b1 ();

    instr_encoder #(.IMEM_AW(8), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .bus(b0),
        .busy(busy0), .done(done0), .err(err0), .err_op(err_op0),
        .err_count(err_count0), .dbg(dbg0)
    );

    instr_encoder #(.IMEM_AW(2), .ERR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .bus(b1),
        .busy(busy1), .done(done1), .err(err1), .err_op(err_op1),
        .err_count(err_count1), .dbg(dbg1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [39:0] exp_q[$];
    logic [39:0] got0_q[$];
    logic [39:0] got1_q[$];

    // Record every completed memory write as {addr, data}.
    always @(negedge clk) begin
        if (b0.imem_we && b0.imem_ready) got0_q.push_back({b0.imem_addr, b0.imem_wdata});
        if (b1.imem_we && b1.imem_ready) got1_q.push_back({6'b0, b1.imem_addr, b1.imem_wdata});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sel, input logic [7:0] b);
        if (sel == 0) begin start0 = 1'b1; base0 = b; end
        else          begin start1 = 1'b1; base1 = b[1:0]; end
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send(input int sel, input logic [4:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [31:0] imm, input logic last);
        int n = 0;
        if (sel == 0) begin
            b0.in_valid = 1'b1; b0.in_op = op; b0.in_rd = rd; b0.in_rs1 = rs1;
            b0.in_rs2 = rs2; b0.in_imm = imm; b0.in_last = last;
        end else begin
            b1.in_valid = 1'b1; b1.in_op = op; b1.in_rd = rd; b1.in_rs1 = rs1;
            b1.in_rs2 = rs2; b1.in_imm = imm; b1.in_last = last;
        end
        #1;
        while (((sel == 0) ? b0.in_ready : b1.in_ready) !== 1'b1 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL send_accept: in_ready stayed low for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (((sel == 0) ? done0 : done1) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL done_timeout: done not seen within %0d cycles, required pulse", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_checks++; if (b0.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", b0.imem_we); end
        n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", b0.in_ready); end
        n_checks++; if ({busy0, done0, err0} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b required 000", {busy0, done0, err0}); end
        n_checks++; if (err_count0 !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", err_count0); end
        n_checks++; if (b0.imem_addr !== 8'd0 || b0.imem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_bus: got %h/%h required 0/0", b0.imem_addr, b0.imem_wdata); end
        n_checks++; if (dbg0.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", dbg0.state, ST_IDLE); end
        n_checks++; if (b1.imem_we !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_dut1: got we=%b busy=%b required 0/0", b1.imem_we, busy1); end
    endtask

    task automatic test_add();
        got0_q.delete();
        b0.imem_ready = 1'b1;
        do_start(0, 8'h00);
        n_checks++; if (busy0 !== 1'b1 || b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_load: got busy=%b rdy=%b required 1/1", busy0, b0.in_ready); end
        send(0, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);
        n_checks++; if (b0.imem_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b required 1", b0.imem_we); end
        n_checks++; if (b0.imem_addr !== 8'h00) begin n_fail++; $display("FAIL add_addr: got %h required 00", b0.imem_addr); end
        n_checks++; if (b0.imem_wdata !== 32'h09890000) begin n_fail++; $display("FAIL add_data: got %h required 09890000", b0.imem_wdata); end
        step();
        n_checks++; if (b0.imem_we !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b required 0", b0.imem_we); end
        exp_q.push_back({8'h00, 32'h09890000});
    endtask

    task automatic test_addi();
        send(0, OP_ADDI, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b0);
        n_checks++; if (b0.imem_addr !== 8'h01) begin n_fail++; $display("FAIL addi_addr: got %h required 01", b0.imem_addr); end
        n_checks++; if (b0.imem_wdata !== 32'h8087FFFF) begin n_fail++; $display("FAIL addi_data: got %h required 8087ffff", b0.imem_wdata); end
        exp_q.push_back({8'h01, 32'h8087FFFF});
        send(0, OP_ADDI, 4'd1, 4'd0, 4'd0, 32'd262144, 1'b1);
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL addi_err: got %b required 1", err0); end
        n_checks++; if (err_op0 !== OP_ADDI) begin n_fail++; $display("FAIL addi_err_op: got %b required 10000", err_op0); end
        n_checks++; if (err_count0 !== 8'd1) begin n_fail++; $display("FAIL addi_err_count: got %0d required 1", err_count0); end
        n_checks++; if (b0.imem_we !== 1'b0) begin n_fail++; $display("FAIL addi_no_write: got %b required 0", b0.imem_we); end
        wait_done(0);
        step();
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL addi_done_pulse: got done=%b busy=%b required 0/0", done0, busy0); end
        n_checks++; if (got0_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL addi_wr_count: got %0d required %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL addi_wr%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_reject();
        got0_q.delete();
        do_start(0, 8'h10);
        n_checks++; if (err0 !== 1'b0 || err_count0 !== 8'd0) begin n_fail++; $display("FAIL rej_clear: got err=%b cnt=%0d required 0/0", err0, err_count0); end
        send(0, OP_SRL, 4'd1, 4'd1, 4'd0, 32'd32, 1'b0);
        b0.in_op = 5'b00110;
        #1;
        n_checks++; if (dbg0.in_cls !== CLS_ILLEGAL) begin n_fail++; $display("FAIL rej_class: got %0d required %0d", dbg0.in_cls, CLS_ILLEGAL); end
        step();
        send(0, 5'b00110, 4'd1, 4'd1, 4'd1, 32'd0, 1'b1);
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL rej_err: got %b required 1", err0); end
        n_checks++; if (err_op0 !== OP_SRL) begin n_fail++; $display("FAIL rej_err_op: got %b required 10001", err_op0); end
        n_checks++; if (err_count0 !== 8'd2) begin n_fail++; $display("FAIL rej_err_count: got %0d required 2", err_count0); end
        wait_done(0);
        n_checks++; if (got0_q.size() !== 0) begin n_fail++; $display("FAIL rej_no_write: got %0d writes required 0", got0_q.size()); end
    endtask

    task automatic test_boundary();
        got0_q.delete();
        do_start(0, 8'h40);
        b0.in_op = OP_SLL;
        #1;
        n_checks++; if (dbg0.in_cls !== CLS_SHIFT) begin n_fail++; $display("FAIL bnd_class: got %0d required %0d", dbg0.in_cls, CLS_SHIFT); end
        step();
        send(0, OP_SLL, 4'd1, 4'd2, 4'd0, 32'd31, 1'b0);
        send(0, OP_ADDI, 4'd1, 4'd0, 4'd0, 32'hFFFC_0000, 1'b0);
        send(0, OP_BGT, 4'd5, 4'd1, 4'd2, 32'd262143, 1'b1);
        exp_q.push_back({8'h40, 32'h9090001F});
        exp_q.push_back({8'h41, 32'h80840000});
        exp_q.push_back({8'h42, 32'h4893FFFF});
        wait_done(0);
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL bnd_err: got %b required 0", err0); end
        n_checks++; if (got0_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bnd_wr_count: got %0d required %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bnd_wr%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        got0_q.delete();
        b0.imem_ready = 1'b1;
        do_start(0, 8'h20);
        send(0, OP_SUB, 4'd2, 4'd3, 4'd4, 32'd0, 1'b0);
        send(0, OP_LW, 4'd5, 4'd6, 4'd0, 32'd100, 1'b0);
        b0.imem_ready = 1'b0;
        b0.in_valid = 1'b1; b0.in_op = OP_BEQ; b0.in_rd = 4'd0; b0.in_rs1 = 4'd7;
        b0.in_rs2 = 4'd8; b0.in_imm = 32'hFFFF_FFF8; b0.in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_rdy%0d: got %b required 0", c, b0.in_ready); end
            n_checks++; if (b0.imem_we !== 1'b1 || b0.imem_addr !== 8'h21 || b0.imem_wdata !== 32'hAAB00064) begin
                n_fail++; $display("FAIL b2b_hold%0d: got %b/%h/%h required 1/21/aab00064", c, b0.imem_we, b0.imem_addr, b0.imem_wdata);
            end
            @(posedge clk);
            #1;
        end
        b0.imem_ready = 1'b1;
        send(0, OP_BEQ, 4'd0, 4'd7, 4'd8, 32'hFFFF_FFF8, 1'b1);
        exp_q.push_back({8'h20, 32'h191A0000});
        exp_q.push_back({8'h21, 32'hAAB00064});
        exp_q.push_back({8'h22, 32'h43C7FFF8});
        wait_done(0);
        n_checks++; if (got0_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_wr_count: got %0d required %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            n_checks++; if (got0_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_wr%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_full();
        got1_q.delete();
        b1.imem_ready = 1'b1;
        do_start(1, 8'h03);
        b1.in_op = OP_ADD;
        #1;
        n_checks++; if (dbg1.in_cls !== CLS_R) begin n_fail++; $display("FAIL full_class: got %0d required %0d", dbg1.in_cls, CLS_R); end
        step();
        send(1, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);
        n_checks++; if (b1.imem_addr !== 2'd3 || b1.imem_we !== 1'b1) begin n_fail++; $display("FAIL full_first: got we=%b addr=%0d required 1/3", b1.imem_we, b1.imem_addr); end
        send(1, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, 1'b1);
        n_checks++; if (err1 !== 1'b1 || err_count1 !== 8'd1) begin n_fail++; $display("FAIL full_err: got err=%b cnt=%0d required 1/1", err1, err_count1); end
        n_checks++; if (err_op1 !== OP_ADD) begin n_fail++; $display("FAIL full_err_op: got %b required 00001", err_op1); end
        n_checks++; if (b1.imem_we !== 1'b0) begin n_fail++; $display("FAIL full_no_write: got %b required 0", b1.imem_we); end
        exp_q.push_back({6'b0, 2'd3, 32'h09890000});
        wait_done(1);
        step();
        n_checks++; if (busy1 !== 1'b0 || dbg1.state !== ST_IDLE) begin n_fail++; $display("FAIL full_idle: got busy=%b state=%0d required 0/0", busy1, dbg1.state); end
        n_checks++; if (got1_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_wr_count: got %0d required %0d", got1_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            n_checks++; if (got1_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_wr%0d: got %h required %h", i, got1_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        got0_q.delete();
        b0.imem_ready = 1'b0;
        do_start(0, 8'h50);
        send(0, OP_ADD, 4'd3, 4'd1, 4'd2, 32'd0, 1'b1);
        n_checks++; if (b0.imem_we !== 1'b1 || b0.imem_addr !== 8'h50) begin n_fail++; $display("FAIL rmid_pending: got we=%b addr=%h required 1/50", b0.imem_we, b0.imem_addr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (b0.imem_we !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got we=%b busy=%b required 0/0", b0.imem_we, busy0); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rmid_done%0d: got %b required 0", c, done0); end
            step();
        end
        b0.imem_ready = 1'b1;
        step();
        n_checks++; if (got0_q.size() !== 0) begin n_fail++; $display("FAIL rmid_no_write: got %0d writes required 0", got0_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0;
        b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.in_op = '0; b0.in_rd = '0;
        b0.in_rs1 = '0; b0.in_rs2 = '0; b0.in_imm = '0; b0.imem_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_op = '0; b1.in_rd = '0;
        b1.in_rs1 = '0; b1.in_rs2 = '0; b1.in_imm = '0; b1.imem_ready = 1'b0;
        test_reset();
        test_add();
        test_addi();
        test_reject();
        test_boundary();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder/writer side of the processor's 5-bit-opcode instruction format: the inverse of the decoder that consumes that format.
- Accepts symbolic instructions (opcode plus register and immediate fields) over a valid/ready stream and checks them for legality.
- Packs each legal instruction into a 32-bit word and writes it sequentially into instruction memory through a one-entry registered output stage with backpressure.
- Used as the program loader between the host/UART front end and the instruction memory.

Parameters:
- IMEM_AW, 8: instruction memory address width in words.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load at base_addr.
- base_addr  in  IMEM_AW  first word address of the load.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_last  in  1  marks the final instruction of the program.
- in_op  in  5  opcode.
- in_rd  in  4  destination register (data source register for SB).
- in_rs1  in  4  source register 1.
- in_rs2  in  4  source register 2.
- in_imm  in  32  signed immediate, shift amount or branch offset.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  IMEM_AW  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  high in the LOAD and FLUSH states.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky; set on any rejected instruction.
- err_op  out  5  opcode of the first rejected instruction.
- err_count  out  ERR_W  number of rejected instructions, saturating.

Behaviour:
- Reset values:
  - In IDLE; all outputs 0.
  - Any pending word is discarded; no write is issued.
  - Reset mid-load aborts the load and produces no done pulse.
- FSM states:
  - IDLE: start → LOAD. The write pointer loads base_addr; err, err_op, err_count and the full flag clear. in_ready=0 in IDLE.
  - LOAD: in_ready = !imem_we || imem_ready. A transfer occurs when in_valid && in_ready. A transfer with in_last → FLUSH.
  - FLUSH: in_ready=0. Wait until the output register is empty (!imem_we, or imem_ready this cycle), then assert done for 1 cycle → IDLE.
  - start is ignored outside IDLE.
- Word formats (bit 31 is the MSB):
  - R-type (ADD 00001, AND 00010, SUB 00011, MUL 00100, CNB 00101, MOD 00111): [31:27]=op, [26:23]=rd, [22:19]=rs1, [18:15]=rs2, [14:0]=0.
  - I-type (ADDI 10000, SRL 10001, SLL 10010, SB 10011, LB 10100, LW 10101): [31:27]=op, [26:23]=rd, [22:19]=rs1, [18:0]=imm19.
  - B-type (BEQ 01000, BGT 01001): [31:27]=op, [26:23]=rs1, [22:19]=rs2, [18:0]=offset19.
- Legality checks:
  - ADDI, SB, LB, LW and branches: in_imm must lie in -262144..262143. The field holds the low 19 bits in two's complement.
  - SRL and SLL: in_imm must be in 0..31, zero-extended into the field.
  - Any opcode not listed above (e.g. 00000, 00110, 01010..01111, 10110..11111) is illegal.
- Handling of a rejected instruction:
  - No word is written and the write pointer is unchanged.
  - err is set; err_op is captured only if err was 0; err_count increments and saturates at all-ones.
  - The transfer still completes. A rejected instruction with in_last still → FLUSH.
- Latency and output handshake:
  - A legal instruction accepted in cycle N appears in cycle N+1 with imem_we=1, its address and its data.
  - imem_addr, imem_wdata and imem_we hold stable until imem_ready is 1.
  - On each completed write (imem_we && imem_ready) the pointer increments by 1.
  - A simultaneous completed write and new accept reloads the register with no bubble, giving full throughput.
- Address space full:
  - After the word at address 2^IMEM_AW-1 is written, the full flag sets. The pointer does not wrap.
  - Subsequent legal instructions are rejected as errors, with err_op set to their opcode.
  - in_ready remains governed by the handshake, so the host drains normally.

Decomposition:
- Shared package isa_pkg:
  - 5-bit opcode localparams for the 14 opcodes listed above.
  - Field position and width constants (OP_MSB=31, OP_LSB=27, REG_W=4, IMM_W=19).
  - instr_class_e enum: CLS_R, CLS_I, CLS_SHIFT, CLS_B, CLS_ILLEGAL.
  - The control unit imports the same opcode constants.
- Sub-module instr_pack:
  - Purely combinational; maps op and fields to {class, legal, word}.
  - Enables reuse by a disassembler checker in the bench.
- The top level holds the FSM, the write pointer, the output register and the error logic.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, base_addr=0, imem_ready=1 → next cycle imem_addr=0, imem_wdata=0x09890000; pointer becomes 1.
- ADDI rd=1 rs1=0 imm=-1 then imm=262144 → first word 0x8087FFFF written. Second is rejected: err=1, err_op=10000, err_count=1, no write.
- SRL imm=32, then op 00110 with in_last → both rejected; err_op=10001, err_count=2. FLUSH then one-cycle done; nothing written.
- Three legal instructions, imem_ready low for 3 cycles on the second → in_ready=0 while stalled; data and address held. Writes land at base, base+1, base+2 in order with no loss.
- IMEM_AW=2, base_addr=3, two legal instructions → first written at 3. Second is rejected (full), err_count=1.
- rst asserted in the cycle a word is pending → imem_we=0 next cycle, busy=0, no done pulse.
